vending_machine_multi: RTL



---
 rtl/vm_pkg.sv | 32 +++
 rtl/vm_stock_bank.sv | 28 ++
 rtl/vending_machine_multi.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared types, coin denominations and helpers for the multi-item vending controller.
package vm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vm_state_e;

    localparam int unsigned COIN_1  = 1;
    localparam int unsigned COIN_5  = 5;
    localparam int unsigned COIN_10 = 10;
    localparam int unsigned COIN_50 = 50;

    // Price vectors are zero-extended to this width so price_of() needs no parameters.
    localparam int unsigned PRICE_VEC_W = 1024;

    function automatic logic is_valid_coin(input logic [31:0] coin);
        return (coin == COIN_1) || (coin == COIN_5) || (coin == COIN_10) || (coin == COIN_50);
    endfunction

    // Item idx (1-based) occupies bits [idx*money_w-1 -: money_w].
    function automatic logic [31:0] price_of(input logic [PRICE_VEC_W-1:0] prices,
                                             input int unsigned idx,
                                             input int unsigned money_w);
        logic [PRICE_VEC_W-1:0] shifted;
        shifted = prices >> ((idx - 1) * money_w);
        return shifted[31:0] & ((32'd1 << money_w) - 32'd1);
    endfunction

endpackage

// File: rtl/vm_stock_bank.sv
// Per-item stock counters: loaded on reset, one-hot decrement, combinational sold-out flags.
module vm_stock_bank #(
    parameter int unsigned N_ITEMS    = 4,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               dec_en_i,
    input  logic [N_ITEMS-1:0] dec_sel_i,
    output logic [N_ITEMS-1:0] sold_out_o
);

    for (genvar g = 0; g < N_ITEMS; g++) begin : g_item
        logic [STOCK_W-1:0] stock_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                stock_q <= STOCK_W'(STOCK_INIT);
            end else if (dec_en_i && dec_sel_i[g] && (stock_q != '0)) begin
                stock_q <= stock_q - STOCK_W'(1);
            end
        end

        assign sold_out_o[g] = (stock_q == '0);
    end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-item vending controller: coin validation, credit, selection, vend and change FSM.
// Optional idle auto-refund is enabled by defining VM_AUTO_REFUND_EN.
module vending_machine_multi
    import vm_pkg::*;
#(
    parameter int unsigned N_ITEMS    = 4,
    parameter int unsigned MONEY_W    = 8,
    parameter int unsigned CHOICE_W   = 4,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 3,
    parameter int unsigned MAX_CREDIT = 200,
    parameter logic [N_ITEMS*MONEY_W-1:0] PRICES = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MONEY_W-1:0]  input_money,
    input  logic [CHOICE_W-1:0] choice,
    input  logic                cancel,
    output logic [MONEY_W-1:0]  total_money,
    output logic [CHOICE_W-1:0] give,
    output logic [MONEY_W-1:0]  refund,
    output logic                reject_coin,
    output logic                deny,
    output logic [N_ITEMS-1:0]  sold_out
);

    localparam logic [PRICE_VEC_W-1:0] PRICES_EXT = PRICE_VEC_W'(PRICES);

    vm_state_e           state_q, state_d;
    logic [MONEY_W-1:0]  credit_q, credit_d;
    logic [MONEY_W-1:0]  price_q, price_d;
    logic [CHOICE_W-1:0] give_q, give_d;
    logic [MONEY_W-1:0]  refund_q, refund_d;
    logic                reject_q, reject_d;
    logic                deny_q, deny_d;

    logic                coin_present;
    logic [MONEY_W:0]    coin_sum;
    logic                coin_ok;
    logic                sel_valid;
    logic                sel_sold;
    logic [MONEY_W-1:0]  sel_price;
    logic [N_ITEMS-1:0]  sel_onehot;
    logic                dec_en;
    logic                auto_cancel;

    assign coin_present = (input_money != '0);
    assign coin_sum     = {1'b0, credit_q} + {1'b0, input_money};
    assign coin_ok      = is_valid_coin(32'(input_money)) && (coin_sum <= (MONEY_W+1)'(MAX_CREDIT));

    always_comb begin
        sel_valid  = 1'b0;
        sel_sold   = 1'b0;
        sel_price  = '0;
        sel_onehot = '0;
        for (int unsigned i = 1; i <= N_ITEMS; i++) begin
            if (32'(choice) == i) begin
                sel_valid  = 1'b1;
                sel_onehot = N_ITEMS'(1) << (i - 1);
                sel_sold   = |(sold_out & sel_onehot);
                sel_price  = MONEY_W'(price_of(PRICES_EXT, i, MONEY_W));
            end
        end
    end

`ifdef VM_AUTO_REFUND_EN
    logic [31:0] idle_cnt_q;
    logic        activity;

    assign activity    = coin_present || (choice != '0) || cancel;
    assign auto_cancel = (state_q == CREDIT) && !activity && (idle_cnt_q == 32'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || (state_q != CREDIT) || activity || auto_cancel) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_q + 32'd1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign auto_cancel    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        price_d  = price_q;
        give_d   = '0;
        refund_d = '0;
        reject_d = 1'b0;
        deny_d   = 1'b0;
        dec_en   = 1'b0;
        case (state_q)
            IDLE, CREDIT: begin
                // Arbitration: cancel beats choice beats coin; both only act once credit exists.
                if ((state_q == CREDIT) && (cancel || auto_cancel)) begin
                    refund_d = credit_q;
                    credit_d = '0;
                    state_d  = CHANGE;
                    reject_d = coin_present;
                end else if ((state_q == CREDIT) && (choice != '0)) begin
                    reject_d = coin_present;
                    if (!sel_valid || sel_sold || (credit_q < sel_price)) begin
                        deny_d = 1'b1;
                    end else begin
                        give_d  = choice;
                        dec_en  = 1'b1;
                        price_d = sel_price;
                        state_d = VEND;
                    end
                end else if (coin_present) begin
                    if (coin_ok) begin
                        credit_d = coin_sum[MONEY_W-1:0];
                        state_d  = CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            VEND: begin
                refund_d = credit_q - price_q;
                credit_d = '0;
                reject_d = coin_present;
                state_d  = CHANGE;
            end
            CHANGE: begin
                reject_d = coin_present;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            price_q  <= '0;
            give_q   <= '0;
            refund_q <= '0;
            reject_q <= 1'b0;
            deny_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            price_q  <= price_d;
            give_q   <= give_d;
            refund_q <= refund_d;
            reject_q <= reject_d;
            deny_q   <= deny_d;
        end
    end

    vm_stock_bank #(
        .N_ITEMS   (N_ITEMS),
        .STOCK_W   (STOCK_W),
        .STOCK_INIT(STOCK_INIT)
    ) u_stock (
        .clk       (clk),
        .reset     (reset),
        .dec_en_i  (dec_en),
        .dec_sel_i (sel_onehot),
        .sold_out_o(sold_out)
    );

    assign total_money = credit_q;
    assign give        = give_q;
    assign refund      = refund_q;
    assign reject_coin = reject_q;
    assign deny        = deny_q;

endmodule
